// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
// Provides the write-port FSM state encoding, the default register-index
// width, the power-on values of sp/tp, and init_value(), which maps a
// register index to its power-on value.
package regfile_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  localparam int unsigned SP_IDX_DEFAULT = 2;
  localparam int unsigned TP_IDX_DEFAULT = 4;
  localparam logic [REG_DATA_W-1:0] SP_INIT_DEFAULT = 32'h4000_0000;
  localparam logic [REG_DATA_W-1:0] TP_INIT_DEFAULT = 32'h1000_0000;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Power-on value of a register with the default sp/tp placement.
  function automatic logic [REG_DATA_W-1:0] init_value(input logic [REG_IDX_W-1:0] idx);
    if (idx == REG_IDX_W'(SP_IDX_DEFAULT)) return SP_INIT_DEFAULT;
    if (idx == REG_IDX_W'(TP_IDX_DEFAULT)) return TP_INIT_DEFAULT;
    return '0;
  endfunction

endpackage

// File: rtl/regfile_write_port_ctrl_if.sv
// Core write-back request channel into the register-file write port.
//   wr_en    core write valid
//   wr_addr  destination register index
//   wr_data  write data
//   wr_ready write port can accept
// Handshake: a write transfers on every clk edge where wr_en && wr_ready;
// wr_addr/wr_data are only meaningful while wr_en is high, and the core
// must hold them stable until the transfer happens.
interface regfile_write_port_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) ();

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/regfile_write_port_ctrl.sv
// Write-side front end of the block-RAM register file.
// After hwrst, or on init_req, sweeps every entry with its power-on value
// (sp/tp get their initial pointers, everything else 0) while stalling the
// core. Otherwise forwards core writes to RAM port A one cycle later and
// drops writes to x0.
// Ports:
//   clk, hwrst  clock and synchronous active-high reset
//   init_req    single-cycle software re-initialisation request
//   bus         core write channel (slave side)
//   init_busy   sweep in progress
//   init_done   one-cycle pulse in the first RUN cycle after a sweep
//   ram_*       registered RAM port A controls
//   dbg_state   current FSM state
module regfile_write_port_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = REG_IDX_W,
  parameter int DATA_DEPTH = 32,
  parameter int SP_IDX = SP_IDX_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] SP_INIT = SP_INIT_DEFAULT,
  parameter int TP_IDX = TP_IDX_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] TP_INIT = TP_INIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      hwrst,
  input  logic                      init_req,
  regfile_write_port_ctrl_if.slave  bus,
  output logic                      init_busy,
  output logic                      init_done,
  output logic                      ram_ena,
  output logic                      ram_wea,
  output logic [ADDR_WIDTH-1:0]     ram_addra,
  output logic [DATA_WIDTH-1:0]     ram_dia,
  output state_t                    dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DATA_DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  // Index swept this cycle: a restart request inside a sweep jumps straight
  // to x0 so the very next RAM write is x0.
  logic [ADDR_WIDTH-1:0] sweep_idx;

  function automatic logic [DATA_WIDTH-1:0] sweep_value(input logic [ADDR_WIDTH-1:0] idx);
    if (idx == ADDR_WIDTH'(SP_IDX)) return SP_INIT;
    if (idx == ADDR_WIDTH'(TP_IDX)) return TP_INIT;
    return '0;
  endfunction

  assign sweep_idx    = init_req ? '0 : cnt;
  assign bus.wr_ready = (state == ST_RUN);
  assign init_busy    = (state == ST_INIT);
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (hwrst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      ram_ena   <= 1'b0;
      ram_wea   <= 1'b0;
      ram_addra <= '0;
      ram_dia   <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b0;
      case (state)
        ST_INIT: begin
          ram_ena   <= 1'b1;
          ram_wea   <= 1'b1;
          ram_addra <= sweep_idx;
          ram_dia   <= sweep_value(sweep_idx);
          // Terminal compare on DATA_DEPTH-1, never on counter wrap.
          if (sweep_idx == LAST_IDX) begin
            state     <= ST_RUN;
            cnt       <= '0;
            init_done <= 1'b1;
          end else begin
            cnt <= sweep_idx + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          // Writes to x0 complete the handshake but never reach the RAM.
          if (bus.wr_en && (bus.wr_addr != '0)) begin
            ram_ena   <= 1'b1;
            ram_wea   <= 1'b1;
            ram_addra <= bus.wr_addr;
            ram_dia   <= bus.wr_data;
          end else begin
            ram_ena <= 1'b0;
            ram_wea <= 1'b0;
          end
          if (init_req) begin
            state <= ST_INIT;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_port_ctrl.sv
module tb_regfile_write_port_ctrl;
  import regfile_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic hwrst;
  logic init_req;
  logic init_busy;
  logic init_done;
  logic ram_ena;
  logic ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dia;
  state_t dbg_state;

  regfile_write_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_write_port_ctrl dut (
    .clk       (clk),
    .hwrst     (hwrst),
    .init_req  (init_req),
    .bus       (bus),
    .init_busy (init_busy),
    .init_done (init_done),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dia   (ram_dia),
    .dbg_state (dbg_state)
  );

  // Port-A RAM model attached to the DUT outputs; read directly by the bench.
  logic [DW-1:0] ram_mem [32];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dia;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one active edge; returns on the following falling edge.
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    init_req    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  // Expected power-on value, written independently of the package helper.
  function automatic logic [DW-1:0] pov(input int idx);
    if (idx == 2) return 32'h4000_0000;
    if (idx == 4) return 32'h1000_0000;
    return 32'h0;
  endfunction

  // Checks a full 32-cycle sweep starting at the next edge.
  task automatic check_sweep(input string tag);
    for (int k = 0; k < 32; k++) begin
      cycle();
      chk({tag, "_ena"}, DW'(ram_ena), 32'd1);
      chk({tag, "_wea"}, DW'(ram_wea), 32'd1);
      chk({tag, "_addra"}, DW'(ram_addra), DW'(k));
      chk({tag, "_dia"}, ram_dia, pov(k));
      chk({tag, "_done"}, DW'(init_done), (k == 31) ? 32'd1 : 32'd0);
      chk({tag, "_ready"}, DW'(bus.wr_ready), (k == 31) ? 32'd1 : 32'd0);
      chk({tag, "_busy"}, DW'(init_busy), (k == 31) ? 32'd0 : 32'd1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    hwrst = 1'b1;
    drive_idle();
    repeat (3) cycle();

    chk("rst_ena", DW'(ram_ena), 32'd0);
    chk("rst_wea", DW'(ram_wea), 32'd0);
    chk("rst_addra", DW'(ram_addra), 32'd0);
    chk("rst_dia", ram_dia, 32'd0);
    chk("rst_busy", DW'(init_busy), 32'd1);
    chk("rst_ready", DW'(bus.wr_ready), 32'd0);
    chk("rst_done", DW'(init_done), 32'd0);

    // Power-on sweep
    hwrst = 1'b0;
    check_sweep("sweep0");
    cycle();
    chk("post_sweep_done", DW'(init_done), 32'd0);
    chk("post_sweep_ena", DW'(ram_ena), 32'd0);
    chk("post_sweep_state", DW'(dbg_state), DW'(ST_RUN));
    chk("ram_sp", ram_mem[2], 32'h4000_0000);
    chk("ram_tp", ram_mem[4], 32'h1000_0000);
    chk("ram_x31", ram_mem[31], 32'h0);

    // Ordinary write to x10
    drive_write(5'd10, 32'hDEAD_BEEF);
    chk("w10_ready", DW'(bus.wr_ready), 32'd1);
    cycle();
    drive_idle();
    chk("w10_ena", DW'(ram_ena), 32'd1);
    chk("w10_wea", DW'(ram_wea), 32'd1);
    chk("w10_addra", DW'(ram_addra), 32'd10);
    chk("w10_dia", ram_dia, 32'hDEAD_BEEF);
    cycle();
    chk("w10_ram", ram_mem[10], 32'hDEAD_BEEF);
    chk("w10_idle_ena", DW'(ram_ena), 32'd0);

    // Write to x0 is accepted but dropped
    drive_write(5'd0, 32'h1234_5678);
    chk("w0_ready", DW'(bus.wr_ready), 32'd1);
    cycle();
    drive_idle();
    chk("w0_ena", DW'(ram_ena), 32'd0);
    chk("w0_wea", DW'(ram_wea), 32'd0);
    cycle();
    chk("w0_ram", ram_mem[0], 32'h0);

    // init_req together with a core write
    init_req = 1'b1;
    drive_write(5'd5, 32'hA5A5_A5A5);
    cycle();
    drive_idle();
    chk("ireq_w_ena", DW'(ram_ena), 32'd1);
    chk("ireq_w_addra", DW'(ram_addra), 32'd5);
    chk("ireq_w_dia", ram_dia, 32'hA5A5_A5A5);
    chk("ireq_w_ready", DW'(bus.wr_ready), 32'd0);
    chk("ireq_w_busy", DW'(init_busy), 32'd1);
    check_sweep("sweep1");
    cycle();
    chk("sweep1_x5", ram_mem[5], 32'h0);
    chk("sweep1_x10", ram_mem[10], 32'h0);
    chk("sweep1_sp", ram_mem[2], 32'h4000_0000);

    // Reset in the middle of a sweep (when cnt reaches 17)
    init_req = 1'b1;
    cycle();
    init_req = 1'b0;
    for (int k = 0; k < 17; k++) cycle();
    chk("mid_addra16", DW'(ram_addra), 32'd16);
    hwrst = 1'b1;
    cycle();
    chk("mid_rst_ena", DW'(ram_ena), 32'd0);
    chk("mid_rst_wea", DW'(ram_wea), 32'd0);
    chk("mid_rst_addra", DW'(ram_addra), 32'd0);
    chk("mid_rst_dia", ram_dia, 32'd0);
    chk("mid_rst_busy", DW'(init_busy), 32'd1);
    chk("mid_rst_ready", DW'(bus.wr_ready), 32'd0);
    cycle();
    chk("mid_rst_ena2", DW'(ram_ena), 32'd0);
    hwrst = 1'b0;
    check_sweep("sweep2");

    // Five back-to-back writes x1..x5 with data 1..5
    for (int i = 1; i <= 5; i++) begin
      drive_write(AW'(i), DW'(i));
      exp_q.push_back(DW'(i));
      cycle();
      chk("b2b_ena", DW'(ram_ena), 32'd1);
      chk("b2b_addra", DW'(ram_addra), DW'(i));
      chk("b2b_dia", ram_dia, exp_q.pop_front());
    end
    drive_idle();
    cycle();
    chk("b2b_end_ena", DW'(ram_ena), 32'd0);
    for (int i = 1; i <= 5; i++) chk("b2b_ram", ram_mem[i], DW'(i));
    chk("pkg_init_value_sp", init_value(5'd2), pov(2));

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
